// File: rtl/crc_pkg.sv
// Purpose : shared state encoding and USB CRC constants for the serial CRC engine.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } crc_state_t;

  // Token CRC5
  localparam logic [4:0]  USB_CRC5_POLY  = 5'h05;
  localparam logic [4:0]  USB_CRC5_INIT  = 5'h1F;
  localparam logic [4:0]  USB_CRC5_RES   = 5'h0C;

  // Data CRC16
  localparam logic [15:0] USB_CRC16_POLY = 16'h8005;
  localparam logic [15:0] USB_CRC16_INIT = 16'hFFFF;
  localparam logic [15:0] USB_CRC16_RES  = 16'h800D;

endpackage

// File: rtl/crc_emit_counter.sv
// Purpose : counts emitted CRC bits and flags the last one (count == MAX-1).
// Latency : rollover is combinational from the count register and count_enable.
// Backpressure: none; counts every enabled cycle, clear wins over count_enable.
//
// Ports: clk, n_rst (async active-low), clear (sync zero), count_enable,
//        rollover (high on the enabled cycle where count == MAX-1).
module crc_emit_counter #(
  parameter int unsigned MAX = 16
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic count_enable,
  output logic rollover
);

  localparam int unsigned CW = (MAX > 1) ? $clog2(MAX) : 1;

  logic [CW-1:0] count_q;

  assign rollover = count_enable && (count_q == CW'(MAX - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (count_enable) begin
      count_q <= rollover ? '0 : count_q + CW'(1);
    end
  end

endmodule

// File: rtl/flex_crc_lfsr.sv
// Purpose : parametrised serial CRC (any width/poly), accumulates LSB-first bits,
//           serialises ~crc MSB-first on request and flags a good residual.
// Latency : crc_value/crc_ok one cycle after a shift_enable edge; emission spans
//           WIDTH cycles starting the cycle after emit_start.
// Backpressure: none; shift_enable/emit_start are ignored while emitting.
//
// Ports: clk, n_rst (async active-low), clear, shift_enable, serial_in, emit_start,
//        serial_out, emit_active, emit_done, crc_value (~crc), crc_ok.
// Build option: CRC_RESIDUAL_CHECK_EN enables the residual comparator; without it
//        crc_ok is tied low and RESIDUAL is unused (transmit-only build).
module flex_crc_lfsr
  import crc_pkg::*;
#(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] POLY     = USB_CRC16_POLY,
  parameter logic [WIDTH-1:0] INIT     = '1,
  parameter logic [WIDTH-1:0] RESIDUAL = USB_CRC16_RES
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             shift_enable,
  input  logic             serial_in,
  input  logic             emit_start,
  output logic             serial_out,
  output logic             emit_active,
  output logic             emit_done,
  output logic [WIDTH-1:0] crc_value,
  output logic             crc_ok
);

  crc_state_t       state_q, state_d;
  logic [WIDTH-1:0] crc_q, crc_d;
  logic [WIDTH-1:0] crc_shift, crc_step;
  logic             fb;
  logic             emitting;
  logic             last_bit;

  assign emitting  = (state_q == EMIT);
  assign crc_shift = {crc_q[WIDTH-2:0], 1'b0};
  assign fb        = serial_in ^ crc_q[WIDTH-1];
  assign crc_step  = crc_shift ^ (fb ? POLY : '0);

  // Counting is suppressed by clear so an aborted emission never reports done.
  crc_emit_counter #(
    .MAX (WIDTH)
  ) u_emit_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .count_enable (emitting && !clear),
    .rollover     (last_bit)
  );

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    if (clear) begin
      state_d = IDLE;
      crc_d   = INIT;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          // emit_start outranks shift_enable: a coincident data bit is dropped.
          if (emit_start) begin
            state_d = EMIT;
          end else if (shift_enable) begin
            state_d = ACCUM;
            crc_d   = crc_step;
          end
        end
        EMIT: begin
          if (last_bit) begin
            state_d = IDLE;
            crc_d   = INIT;
          end else begin
            crc_d   = crc_shift;
          end
        end
        default: begin
          state_d = IDLE;
          crc_d   = INIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      crc_q   <= INIT;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
    end
  end

  assign emit_active = emitting;
  assign emit_done   = last_bit;
  assign serial_out  = emitting & ~crc_q[WIDTH-1];
  assign crc_value   = ~crc_q;

`ifdef CRC_RESIDUAL_CHECK_EN
  assign crc_ok = (crc_q == RESIDUAL);
`else
  assign crc_ok = 1'b0;
`endif

endmodule

// File: tb/tb_flex_crc_lfsr.sv
`timescale 1ns/1ps
module tb_flex_crc_lfsr;
  import crc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic n_rst;

  // CRC5 instance (a_*) and CRC16 instance (b_*)
  logic a_clear, a_se, a_si, a_es, a_so, a_act, a_done, a_ok;
  logic [4:0] a_val;
  logic b_clear, b_se, b_si, b_es, b_so, b_act, b_done, b_ok;
  logic [15:0] b_val;

  int checks = 0;
  int errors = 0;
  logic [31:0] m5, m16;   // reference CRC register contents (uncomplemented)

  flex_crc_lfsr #(.WIDTH(5), .POLY(5'h05), .INIT(5'h1F), .RESIDUAL(5'h0C)) u_crc5 (
    .clk(clk), .n_rst(n_rst), .clear(a_clear), .shift_enable(a_se), .serial_in(a_si),
    .emit_start(a_es), .serial_out(a_so), .emit_active(a_act), .emit_done(a_done),
    .crc_value(a_val), .crc_ok(a_ok));

  flex_crc_lfsr #(.WIDTH(16), .POLY(16'h8005), .INIT(16'hFFFF), .RESIDUAL(16'h800D)) u_crc16 (
    .clk(clk), .n_rst(n_rst), .clear(b_clear), .shift_enable(b_se), .serial_in(b_si),
    .emit_start(b_es), .serial_out(b_so), .emit_active(b_act), .emit_done(b_done),
    .crc_value(b_val), .crc_ok(b_ok));

  // Polynomial division view: the data bit is added into the top coefficient,
  // then the register is multiplied by x and reduced modulo the generator.
  function automatic logic [31:0] mstep(input logic [31:0] r, input logic b,
                                        input logic [31:0] poly, input int w);
    logic [31:0] mask, t;
    logic top;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    t    = r ^ ({31'd0, b} << (w - 1));
    top  = t[w-1];
    t    = (t << 1) & mask;
    if (top) t = t ^ poly;
    return t;
  endfunction

  function automatic logic exp_ok(input logic [31:0] r, input logic [31:0] res);
`ifdef CRC_RESIDUAL_CHECK_EN
    return (r == res);
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_clear = 0; a_se = 0; a_si = 0; a_es = 0;
    b_clear = 0; b_se = 0; b_si = 0; b_es = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    n_rst = 0;
    repeat (2) tick();
    n_rst = 1;
    a_se = 1;
    for (int i = 0; i < 3; i++) begin
      a_si = 1'($urandom);
      tick();
    end
    @(negedge clk);
    n_rst = 0;
    #1;
    checks++; if (a_val !== 5'h00) begin errors++; $display("FAIL reset_crc5_value: got %h want 00", a_val); end
    checks++; if (a_act !== 1'b0 || a_so !== 1'b0 || a_done !== 1'b0) begin errors++; $display("FAIL reset_crc5_emit: act=%b so=%b done=%b want 0", a_act, a_so, a_done); end
    checks++; if (a_ok !== 1'b0) begin errors++; $display("FAIL reset_crc5_ok: got %b want 0", a_ok); end
    checks++; if (b_val !== 16'h0000 || b_ok !== 1'b0) begin errors++; $display("FAIL reset_crc16: val=%h ok=%b want 0000/0", b_val, b_ok); end
    tick();
    n_rst = 1;
    a_se = 0;
    m5 = 32'h1F; m16 = 32'hFFFF;
    @(negedge clk);
    checks++; if (a_val !== 5'h00 || a_act !== 1'b0) begin errors++; $display("FAIL reset_release: val=%h act=%b want 00/0", a_val, a_act); end
  endtask

  task automatic test_crc5_single_and_emit();
    tick();
    a_se = 1; a_si = 0;
    tick();
    a_se = 0;
    m5 = mstep(m5, 1'b0, 32'h05, 5);
    @(negedge clk);
    checks++; if (a_val !== 5'h04) begin errors++; $display("FAIL crc5_zero_bit: got %h want 04", a_val); end
    checks++; if (a_val !== ~m5[4:0]) begin errors++; $display("FAIL crc5_zero_model: got %h want %h", a_val, ~m5[4:0]); end
    tick();
    a_es = 1;
    tick();
    a_es = 0;
    for (int i = 0; i < 5; i++) begin
      logic [4:0] pat;
      pat = 5'b00100;   // expected serial_out sequence, first bit in bit 4
      @(negedge clk);
      checks++;
      if (a_so !== pat[4-i] || a_act !== 1'b1 || a_done !== (i == 4)) begin
        errors++;
        $display("FAIL crc5_emit_bit%0d: so=%b act=%b done=%b want %b/1/%b", i, a_so, a_act, a_done, pat[4-i], (i == 4));
      end
      tick();
    end
    m5 = 32'h1F;
    @(negedge clk);
    checks++; if (a_val !== 5'h00 || a_act !== 1'b0 || a_so !== 1'b0) begin errors++; $display("FAIL crc5_emit_end: val=%h act=%b so=%b want 00/0/0", a_val, a_act, a_so); end
  endtask

  task automatic test_crc16_single();
    tick();
    b_se = 1; b_si = 0;
    tick();
    b_se = 0;
    @(negedge clk);
    checks++; if (b_val !== 16'h8004) begin errors++; $display("FAIL crc16_zero_bit: got %h want 8004", b_val); end
    tick();
    b_clear = 1;
    tick();
    b_clear = 0; b_se = 1; b_si = 1;
    tick();
    b_se = 0;
    @(negedge clk);
    checks++; if (b_val !== 16'h0001) begin errors++; $display("FAIL crc16_one_bit: got %h want 0001", b_val); end
    tick();
    b_clear = 1;
    tick();
    b_clear = 0;
    m16 = 32'hFFFF;
  endtask

  task automatic test_residual();
    logic [5:0] good;
    good = 6'b000100;   // bits fed in order good[5] .. good[0] = 0,0,0,1,0,0
    for (int flip = -1; flip < 6; flip++) begin
      a_clear = 1;
      tick();
      a_clear = 0;
      m5 = 32'h1F;
      for (int k = 0; k < 6; k++) begin
        logic bitv;
        bitv = good[5-k] ^ (flip == k);
        a_se = 1; a_si = bitv;
        m5 = mstep(m5, bitv, 32'h05, 5);
        tick();
      end
      a_se = 0;
      @(negedge clk);
      if (flip < 0) begin
        checks++; if (a_val !== 5'h13) begin errors++; $display("FAIL residual_value: got %h want 13", a_val); end
`ifdef CRC_RESIDUAL_CHECK_EN
        checks++; if (a_ok !== 1'b1) begin errors++; $display("FAIL residual_ok: got %b want 1", a_ok); end
`endif
      end
      checks++;
      if (a_ok !== exp_ok(m5, 32'h0C) || a_val !== ~m5[4:0]) begin
        errors++;
        $display("FAIL residual_flip%0d: ok=%b val=%h want %b/%h", flip, a_ok, a_val, exp_ok(m5, 32'h0C), ~m5[4:0]);
      end
    end
    a_clear = 1;
    tick();
    a_clear = 0;
    m5 = 32'h1F;
  endtask

  task automatic test_priority_abort();
    b_clear = 1;
    tick();
    b_clear = 0;
    m16 = 32'hFFFF;
    for (int k = 0; k < 5; k++) begin
      b_se = 1; b_si = 1'($urandom);
      m16 = mstep(m16, b_si, 32'h8005, 16);
      tick();
    end
    b_se = 1; b_si = 1'($urandom); b_es = 1;   // data bit must be dropped
    tick();
    b_se = 0; b_es = 0;
    @(negedge clk);
    checks++; if (b_act !== 1'b1 || b_so !== ~m16[15]) begin errors++; $display("FAIL prio_emit1: act=%b so=%b want 1/%b", b_act, b_so, ~m16[15]); end
    tick();
    b_clear = 1;
    @(negedge clk);
    checks++; if (b_so !== ~m16[14] || b_done !== 1'b0) begin errors++; $display("FAIL prio_emit2: so=%b done=%b want %b/0", b_so, b_done, ~m16[14]); end
    tick();
    b_clear = 0;
    m16 = 32'hFFFF;
    @(negedge clk);
    checks++; if (b_act !== 1'b0 || b_done !== 1'b0 || b_val !== 16'h0000 || b_so !== 1'b0) begin errors++; $display("FAIL prio_abort: act=%b done=%b val=%h so=%b want 0/0/0000/0", b_act, b_done, b_val, b_so); end
  endtask

  task automatic test_random_back_to_back();
    for (int it = 0; it < 8; it++) begin
      int n;
      logic b2b;
      b_clear = 1;
      tick();
      b_clear = 0;
      m16 = 32'hFFFF;
      n = $urandom_range(1, 24);
      b2b = it[0];
      for (int k = 0; k < n; k++) begin
        b_se = ($urandom_range(0, 3) != 0);
        b_si = 1'($urandom);
        tick();
        if (b_se) m16 = mstep(m16, b_si, 32'h8005, 16);
        @(negedge clk);
        checks++;
        if (b_val !== ~m16[15:0] || b_ok !== exp_ok(m16, 32'h800D) || b_act !== 1'b0) begin
          errors++;
          $display("FAIL rand_accum it%0d bit%0d: val=%h ok=%b act=%b want %h/%b/0", it, k, b_val, b_ok, b_act, ~m16[15:0], exp_ok(m16, 32'h800D));
        end
      end
      b_es = 1; b_se = 1'($urandom); b_si = 1'($urandom);
      tick();
      for (int i = 0; i < 16; i++) begin
        if (i < 15) begin b_es = 1'($urandom); b_se = 1'($urandom); b_si = 1'($urandom); end
        else begin b_es = 0; b_se = 0; end
        @(negedge clk);
        checks++;
        if (b_so !== ~m16[15-i] || b_act !== 1'b1 || b_done !== (i == 15)) begin
          errors++;
          $display("FAIL rand_emit it%0d bit%0d: so=%b act=%b done=%b want %b/1/%b", it, i, b_so, b_act, b_done, ~m16[15-i], (i == 15));
        end
        tick();
      end
      m16 = 32'hFFFF;
      b_es = b2b;
      @(negedge clk);
      checks++; if (b_val !== 16'h0000 || b_act !== 1'b0) begin errors++; $display("FAIL rand_after_emit it%0d: val=%h act=%b want 0000/0", it, b_val, b_act); end
      if (b2b) begin
        tick();
        b_es = 0;
        for (int i = 0; i < 16; i++) begin
          @(negedge clk);
          checks++;
          if (b_so !== ~m16[15-i] || b_act !== 1'b1 || b_done !== (i == 15)) begin
            errors++;
            $display("FAIL b2b_emit it%0d bit%0d: so=%b act=%b done=%b want %b/1/%b", it, i, b_so, b_act, b_done, ~m16[15-i], (i == 15));
          end
          tick();
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_emit();
    b_clear = 1;
    tick();
    b_clear = 0; b_se = 1; b_si = 0;
    tick();
    b_se = 0; b_es = 1;
    tick();
    b_es = 0;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (b_act !== 1'b1) begin errors++; $display("FAIL mid_emit_active: got %b want 1", b_act); end
    n_rst = 0;
    #1;
    checks++; if (b_act !== 1'b0 || b_so !== 1'b0 || b_done !== 1'b0 || b_val !== 16'h0000) begin errors++; $display("FAIL mid_emit_reset: act=%b so=%b done=%b val=%h want 0/0/0/0000", b_act, b_so, b_done, b_val); end
    tick();
    n_rst = 1;
    m16 = 32'hFFFF;
    @(negedge clk);
    checks++; if (b_act !== 1'b0 || b_val !== 16'h0000) begin errors++; $display("FAIL mid_emit_release: act=%b val=%h want 0/0000", b_act, b_val); end
  endtask

  initial begin
    test_reset();
    test_crc5_single_and_emit();
    test_crc16_single();
    test_residual();
    test_priority_abort();
    test_random_back_to_back();
    test_reset_mid_emit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flex_crc_lfsr.md
# flex_crc_lfsr

Parametrised serial CRC engine for the USB transmit and receive paths. It generalises the CRC shift register to any width and polynomial, with a selectable initial value and residual. It accumulates a serial bit stream and exposes the complemented CRC in parallel. On request it serialises the complemented CRC MSB-first for appending to a packet, and it flags a good residual on the receive side. One instance per packet type: CRC5 for tokens, CRC16 for data.

## Interface
Parameters:
- WIDTH, 16: CRC register width; legal range 2–32.
- POLY, 16'h8005: generator polynomial, implicit x^WIDTH term omitted.
- INIT, all ones: register value after reset, clear and emit completion.
- RESIDUAL, 16'h800D: register value that indicates an error-free frame (CRC5 uses 5'h0C).

Ports:
- clk, input, 1: system clock, rising edge.
- n_rst, input, 1: asynchronous, active-low reset.
- clear, input, 1: synchronous reload of INIT and return to IDLE.
- shift_enable, input, 1: accumulate serial_in this cycle.
- serial_in, input, 1: data bit, LSB-first packet order as presented by the bit stuffer.
- emit_start, input, 1: begin serialising the CRC.
- serial_out, output, 1: complemented CRC bit, MSB first, valid while emit_active is high.
- emit_active, output, 1: high during the EMIT state.
- emit_done, output, 1: one-cycle pulse on the last emitted bit.
- crc_value, output, WIDTH: ~crc register.
- crc_ok, output, 1: crc register equals RESIDUAL.

## Operation
- States: IDLE, ACCUM and EMIT.
- Accumulate step: fb = serial_in ^ crc[WIDTH-1]; crc <= {crc[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0).
- IDLE: shift_enable performs an accumulate step and moves the block to ACCUM. emit_start moves the block to EMIT.
- ACCUM: shift_enable accumulates. emit_start moves the block to EMIT.
- EMIT: no feedback. Each cycle crc <= {crc[WIDTH-2:0],1'b0} and the emit counter increments.
  - serial_out = ~crc[WIDTH-1], combinational from the register.
  - shift_enable and emit_start are ignored in EMIT.
- End of EMIT: when the counter reaches WIDTH-1, emit_done pulses and the block moves to IDLE. On the following edge crc <= INIT and the counter returns to 0.
- Priority: n_rst, then clear, then emit_start, then shift_enable. If emit_start and shift_enable are both high, the data bit is dropped.
- clear during EMIT aborts the emission; emit_done does not pulse.
- serial_out is 0 whenever emit_active is low.

## Timing
- Reset values:
  - crc = INIT, so crc_value = ~INIT (0 for all-ones INIT).
  - State IDLE, counter 0.
  - serial_out = 0, emit_active = 0, emit_done = 0.
  - crc_ok = (INIT == RESIDUAL).
- Accumulate latency: crc_value and crc_ok reflect a bit one cycle after the shift_enable edge.
- Emission:
  - emit_start sampled at edge N, so emit_active is high from cycle N+1 through N+WIDTH.
  - The first bit ~crc[WIDTH-1] appears in cycle N+1.
  - emit_done is high in cycle N+WIDTH.
- Back-to-back operation: emit_start may be asserted again in the cycle after emit_done. The new emission uses INIT.
- Asynchronous reset mid-EMIT returns immediately to the reset values.

## Configuration
- CRC_RESIDUAL_CHECK_EN defined: crc_ok is a registered-path compare of crc against RESIDUAL.
- CRC_RESIDUAL_CHECK_EN undefined: crc_ok is tied to 0, the comparator is removed and the RESIDUAL parameter is unused. This is the transmit-only build.

## Structure
- Package crc_pkg:
  - state enum crc_state_t {IDLE, ACCUM, EMIT}.
  - Constants USB_CRC5_POLY = 5'h05, USB_CRC5_INIT = 5'h1F, USB_CRC5_RES = 5'h0C.
  - Constants USB_CRC16_POLY = 16'h8005, USB_CRC16_INIT = 16'hFFFF, USB_CRC16_RES = 16'h800D.
- Sub-module crc_emit_counter: counter of width $clog2(WIDTH), with clear, count_enable and rollover flag at WIDTH-1. It drives emit_done.

## Test plan
- Reset with WIDTH=5: n_rst low mid-stream, then release. Expect crc_value = 5'h00, emit_active = 0, crc_ok = 0.
- Single zero bit, CRC5: shift_enable with serial_in = 0. Next cycle crc_value = 5'h04.
- Single bit, CRC16: serial_in = 0 gives crc_value = 16'h8004. After clear, serial_in = 1 gives crc_value = 16'h0001.
- Emission, CRC5 after one 0 bit: emit_start, then serial_out = 0,0,1,0,0 over 5 cycles. emit_done is high in the 5th cycle, then crc_value = 5'h00.
- Residual, CRC5 with macro defined: feed bits 0,0,0,1,0,0. crc_ok = 1 after the 6th bit. Flipping any bit gives crc_ok = 0.
- Priority: emit_start and shift_enable together, then clear in emit cycle 2. Expect the data bit dropped, emit_active low the next cycle, no emit_done pulse, and crc_value = ~INIT.
